// File: rtl/agc_wb_sequencer.sv
// rtl/agc_wb_sequencer.sv - Wishbone initiator sequencing one AGC scale/offset update and measurement readback
//
// Writes scale and offset to the agc_wrapper window, latches and applies them,
// starts the AGC timer, polls the done bit and reads back sq/gt/lt.
//
// Optional feature macro: AGC_SEQ_RESET_EN inserts an AGC-core reset write
// (0x004 to 0x00, sel 0001) as the first transaction of every run.
//
// Ports:
//   wb_clk_i, wb_resetn          clock, synchronous active-low reset
//   start_i, scale_i, offset_i   run request and its operands (sampled on accept)
//   wb_cyc_o .. wb_sel_o         registered Wishbone master outputs
//   wb_dat_i, wb_ack_i,
//   wb_err_i, wb_rty_i           Wishbone target response (rty handled as err)
//   busy_o, done_o               run in progress, one-cycle success pulse
//   err_o, err_code_o            sticky failure flag and cause (1 bus, 2 ack, 3 poll)
//   sq_o, gt_o, lt_o             accumulators from the last successful run

module agc_wb_sequencer #(
    parameter int POLL_GAP   = 64,
    parameter int POLL_LIMIT = 4096,
    parameter int ACK_LIMIT  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_resetn,
    input  logic        start_i,
    input  logic [16:0] scale_i,
    input  logic [15:0] offset_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [24:0] sq_o,
    output logic [20:0] gt_o,
    output logic [20:0] lt_o
);

    typedef enum logic [3:0] {
        S_IDLE,
`ifdef AGC_SEQ_RESET_EN
        S_RST,
`endif
        S_WR_SCALE,
        S_WR_OFFSET,
        S_WR_LOAD,
        S_WR_APPLY,
        S_WR_TICK,
        S_WAIT,
        S_POLL,
        S_RD_SQ,
        S_RD_GT,
        S_RD_LT,
        S_DONE
    } state_t;

    // Each bus state walks ENTRY -> ACTIVE (cyc high) -> GAP (cyc low) before
    // moving on, which guarantees the idle cycle between transactions.
    typedef enum logic [1:0] {
        PH_ENTRY,
        PH_ACTIVE,
        PH_GAP
    } phase_t;

`ifdef AGC_SEQ_RESET_EN
    localparam state_t S_FIRST = S_RST;
`else
    localparam state_t S_FIRST = S_WR_SCALE;
`endif

    localparam logic [15:0] ACK_LAST  = 16'(ACK_LIMIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [15:0] cnt_q;
    logic [15:0] poll_q;
    logic [16:0] scale_q;
    logic [15:0] offset_q;
    logic        poll_done_q;
    logic [24:0] sq_sh;
    logic [20:0] gt_sh;
    logic [20:0] lt_sh;

    logic        accept;
    logic        issue;
    logic        finish;
    logic        fail;
    logic [1:0]  fail_code;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        poll_inc;
    logic        commit;

    logic        tx_we;
    logic [7:0]  tx_adr;
    logic [31:0] tx_dat;
    logic [3:0]  tx_sel;

    // Upper read-data bits are never part of any captured field.
    logic        unused_rdata;
    assign unused_rdata = ^wb_dat_i[31:25];

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        accept    = 1'b0;
        issue     = 1'b0;
        finish    = 1'b0;
        fail      = 1'b0;
        fail_code = 2'd0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        poll_inc  = 1'b0;
        commit    = 1'b0;

        // Transaction descriptor for the current state; reads are the default.
        tx_we  = 1'b0;
        tx_adr = 8'h00;
        tx_dat = 32'h0;
        tx_sel = 4'b1111;
        case (state_q)
`ifdef AGC_SEQ_RESET_EN
            S_RST: begin
                tx_we  = 1'b1;
                tx_dat = 32'h0000_0004;
                tx_sel = 4'b0001;
            end
`endif
            S_WR_SCALE: begin
                tx_we  = 1'b1;
                tx_adr = 8'h10;
                tx_dat = {15'd0, scale_q};
                tx_sel = 4'b0111;
            end
            S_WR_OFFSET: begin
                tx_we  = 1'b1;
                tx_adr = 8'h14;
                tx_dat = {16'd0, offset_q};
                tx_sel = 4'b0011;
            end
            S_WR_LOAD: begin
                tx_we  = 1'b1;
                tx_dat = 32'h0000_0300;
                tx_sel = 4'b0010;
            end
            S_WR_APPLY: begin
                tx_we  = 1'b1;
                tx_dat = 32'h0000_0400;
                tx_sel = 4'b0010;
            end
            S_WR_TICK: begin
                tx_we  = 1'b1;
                tx_dat = 32'h0000_0001;
                tx_sel = 4'b0001;
            end
            S_RD_SQ: tx_adr = 8'h04;
            S_RD_GT: tx_adr = 8'h08;
            S_RD_LT: tx_adr = 8'h0C;
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = S_FIRST;
                    phase_d = PH_ENTRY;
                end
            end
            S_WAIT: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_POLL;
                    phase_d = PH_ENTRY;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                case (phase_q)
                    PH_ENTRY: begin
                        issue   = 1'b1;
                        cnt_clr = 1'b1;
                        phase_d = PH_ACTIVE;
                    end
                    PH_ACTIVE: begin
                        // err/rty take priority over a simultaneous ack.
                        if (wb_err_i || wb_rty_i) begin
                            fail      = 1'b1;
                            fail_code = 2'd1;
                        end else if (wb_ack_i) begin
                            finish  = 1'b1;
                            phase_d = PH_GAP;
                        end else if (cnt_q == ACK_LAST) begin
                            fail      = 1'b1;
                            fail_code = 2'd2;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                    default: begin
                        phase_d = PH_ENTRY;
                        case (state_q)
`ifdef AGC_SEQ_RESET_EN
                            S_RST:       state_d = S_WR_SCALE;
`endif
                            S_WR_SCALE:  state_d = S_WR_OFFSET;
                            S_WR_OFFSET: state_d = S_WR_LOAD;
                            S_WR_LOAD:   state_d = S_WR_APPLY;
                            S_WR_APPLY:  state_d = S_WR_TICK;
                            S_WR_TICK: begin
                                state_d = S_WAIT;
                                cnt_clr = 1'b1;
                            end
                            S_POLL: begin
                                if (poll_done_q) begin
                                    state_d = S_RD_SQ;
                                end else if (poll_q == POLL_LAST) begin
                                    fail      = 1'b1;
                                    fail_code = 2'd3;
                                end else begin
                                    poll_inc = 1'b1;
                                    state_d  = S_WAIT;
                                    cnt_clr  = 1'b1;
                                end
                            end
                            S_RD_SQ: state_d = S_RD_GT;
                            S_RD_GT: state_d = S_RD_LT;
                            S_RD_LT: begin
                                state_d = S_DONE;
                                commit  = 1'b1;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                endcase
            end
        endcase

        if (fail) begin
            state_d = S_IDLE;
            phase_d = PH_ENTRY;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_resetn) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ENTRY;
            cnt_q       <= 16'd0;
            poll_q      <= 16'd0;
            scale_q     <= 17'd0;
            offset_q    <= 16'd0;
            poll_done_q <= 1'b0;
            sq_sh       <= 25'd0;
            gt_sh       <= 21'd0;
            lt_sh       <= 21'd0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= 8'h00;
            wb_dat_o    <= 32'h0;
            wb_sel_o    <= 4'h0;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
            sq_o        <= 25'd0;
            gt_o        <= 21'd0;
            lt_o        <= 21'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;

            if (cnt_clr) begin
                cnt_q <= 16'd0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 16'd1;
            end

            if (accept) begin
                poll_q     <= 16'd0;
                scale_q    <= scale_i;
                offset_q   <= offset_i;
                err_o      <= 1'b0;
                err_code_o <= 2'd0;
            end else if (poll_inc) begin
                poll_q <= poll_q + 16'd1;
            end

            if (issue) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= tx_we;
                wb_adr_o <= tx_adr;
                wb_dat_o <= tx_dat;
                wb_sel_o <= tx_sel;
            end

            if (finish || fail) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end

            if (fail) begin
                err_o      <= 1'b1;
                err_code_o <= fail_code;
            end

            if (finish) begin
                case (state_q)
                    S_POLL:  poll_done_q <= wb_dat_i[1];
                    S_RD_SQ: sq_sh       <= wb_dat_i[24:0];
                    S_RD_GT: gt_sh       <= wb_dat_i[20:0];
                    S_RD_LT: lt_sh       <= wb_dat_i[20:0];
                    default: ;
                endcase
            end

            // Results become visible together while done_o is high.
            if (commit) begin
                sq_o <= sq_sh;
                gt_o <= gt_sh;
                lt_o <= lt_sh;
            end
        end
    end

endmodule

// File: tb/tb_agc_wb_sequencer.sv
// tb/tb_agc_wb_sequencer.sv - self-checking bench for agc_wb_sequencer with a behavioural AGC target

module tb_agc_wb_sequencer;

    localparam int POLL_GAP   = 4;
    localparam int POLL_LIMIT = 4;
    localparam int ACK_LIMIT  = 255;
`ifdef AGC_SEQ_RESET_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic [16:0] scale_i;
    logic [15:0] offset_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [24:0] sq_o;
    logic [20:0] gt_o, lt_o;

    agc_wb_sequencer #(
        .POLL_GAP  (POLL_GAP),
        .POLL_LIMIT(POLL_LIMIT),
        .ACK_LIMIT (ACK_LIMIT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_resetn (resetn),
        .start_i   (start_i),
        .scale_i   (scale_i),
        .offset_i  (offset_i),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_rty_i  (wb_rty_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .err_code_o(err_code_o),
        .sq_o      (sq_o),
        .gt_o      (gt_o),
        .lt_o      (lt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] mk(input logic we, input logic [7:0] a,
                                       input logic [31:0] d, input logic [3:0] s);
        return {we, a, d, s};
    endfunction

    // Target configuration and observation state.
    int          t_lat = 3;
    int          t_dafter = 1;
    int          t_err = -1;
    bit          t_rty = 1'b0;
    bit          t_both = 1'b0;
    int          t_hold = -1;
    logic [31:0] t_sq, t_gt, t_lt;
    int          poll_seen = 0;
    int          tx_num = 0;
    int          cur_idx = 0;
    int          wcnt = 0;
    int          clen = 0;
    int          last_len = 0;
    bit          prev_cyc = 1'b0;
    bit          resp_prev = 1'b0;
    logic [44:0] cap;
    logic [44:0] log_q[$];

    // Target: responds after t_lat cycles of cyc, logs each answered transaction.
    always @(negedge clk) begin
        logic [31:0] d;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = $urandom();
        if (resp_prev && resetn)
            chk("gap_after_response", wb_cyc_o, 0);
        resp_prev = 1'b0;
        if (wb_cyc_o) begin
            if (!prev_cyc) begin
                cur_idx = tx_num;
                tx_num++;
                wcnt = 0;
                clen = 0;
                cap = {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
            end else begin
                chk("bus_stable", {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}, cap);
            end
            chk("stb_with_cyc", wb_stb_o, 1);
            wcnt++;
            clen++;
            if (cur_idx != t_hold && wcnt == t_lat) begin
                log_q.push_back({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o});
                resp_prev = 1'b1;
                if (cur_idx == t_err) begin
                    if (t_rty) wb_rty_i = 1'b1;
                    else       wb_err_i = 1'b1;
                    wb_ack_i = t_both;
                end else begin
                    wb_ack_i = 1'b1;
                    d = $urandom();
                    if (!wb_we_o) begin
                        case (wb_adr_o)
                            8'h00: begin
                                poll_seen++;
                                d[1] = (poll_seen >= t_dafter);
                            end
                            8'h04: d = t_sq;
                            8'h08: d = t_gt;
                            8'h0C: d = t_lt;
                            default: ;
                        endcase
                    end
                    wb_dat_i = d;
                end
            end
        end else if (prev_cyc) begin
            last_len = clen;
        end
        prev_cyc = wb_cyc_o;
    end

    // Reference model state.
    logic [24:0] m_sq = '0;
    logic [20:0] m_gt = '0;
    logic [20:0] m_lt = '0;

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_sq = '0;
        m_gt = '0;
        m_lt = '0;
    endtask

    task automatic run(input logic [16:0] sc, input logic [15:0] of, input int d_after,
                       input int lat, input int err_idx, input bit use_rty, input int hold_idx,
                       input logic [31:0] sq, input logic [31:0] gt, input logic [31:0] lt);
        logic [44:0] exp_q[$];
        int          n;
        int          dones;
        int          npoll;
        bit          ok;
        logic [1:0]  code;

        t_lat = lat; t_dafter = d_after; t_err = err_idx; t_rty = use_rty;
        t_both = ($urandom_range(0, 1) == 1); t_hold = hold_idx;
        t_sq = sq; t_gt = gt; t_lt = lt;
        poll_seen = 0;
        tx_num = 0;
        log_q.delete();

        // Expected bus trace derived from the register-map sequence.
        npoll = (d_after <= POLL_LIMIT) ? d_after : POLL_LIMIT;
        ok    = (d_after <= POLL_LIMIT);
        code  = ok ? 2'd0 : 2'd3;
`ifdef AGC_SEQ_RESET_EN
        exp_q.push_back(mk(1'b1, 8'h00, 32'h4, 4'b0001));
`endif
        exp_q.push_back(mk(1'b1, 8'h10, {15'd0, sc}, 4'b0111));
        exp_q.push_back(mk(1'b1, 8'h14, {16'd0, of}, 4'b0011));
        exp_q.push_back(mk(1'b1, 8'h00, 32'h300, 4'b0010));
        exp_q.push_back(mk(1'b1, 8'h00, 32'h400, 4'b0010));
        exp_q.push_back(mk(1'b1, 8'h00, 32'h001, 4'b0001));
        for (int i = 0; i < npoll; i++)
            exp_q.push_back(mk(1'b0, 8'h00, 32'h0, 4'b1111));
        if (ok) begin
            exp_q.push_back(mk(1'b0, 8'h04, 32'h0, 4'b1111));
            exp_q.push_back(mk(1'b0, 8'h08, 32'h0, 4'b1111));
            exp_q.push_back(mk(1'b0, 8'h0C, 32'h0, 4'b1111));
        end
        if (err_idx >= 0 && err_idx < exp_q.size()) begin
            while (exp_q.size() > err_idx + 1) void'(exp_q.pop_back());
            ok = 1'b0;
            code = 2'd1;
        end
        if (hold_idx >= 0 && hold_idx < exp_q.size()) begin
            while (exp_q.size() > hold_idx) void'(exp_q.pop_back());
            ok = 1'b0;
            code = 2'd2;
        end

        @(negedge clk);
        scale_i = sc;
        offset_i = of;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        scale_i = 17'($urandom());
        offset_i = 16'($urandom());
        chk("start_busy", busy_o, 1);
        chk("start_cyc_low", wb_cyc_o, 0);
        chk("start_err_cleared", {err_o, err_code_o}, 0);
        @(negedge clk);
        chk("first_cyc_latency", wb_cyc_o, 1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;

        n = 0;
        dones = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk);
            start_i = 1'b0;
            n++;
            if (done_o) begin
                dones++;
                chk("sq_at_done", sq_o, sq[24:0]);
                start_i = 1'b1;
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        chk("run_ends_idle", busy_o, 0);
        if (busy_o) do_reset();

        if (ok) begin
            m_sq = sq[24:0];
            m_gt = gt[20:0];
            m_lt = lt[20:0];
        end
        chk("done_pulses", dones, ok ? 1 : 0);
        chk("err_o", err_o, !ok);
        chk("err_code", err_code_o, code);
        chk("sq_o", sq_o, m_sq);
        chk("gt_o", gt_o, m_gt);
        chk("lt_o", lt_o, m_lt);
        if (code != 2'd1 && code != 2'd2) chk("poll_count", poll_seen, npoll);
        if (hold_idx >= 0) chk("ack_wait_cycles", last_len, ACK_LIMIT);
        chk("trace_len", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("trace[%0d]", i), log_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        start_i = 1'b0;
        scale_i = '0;
        offset_i = '0;
        wb_dat_i = '0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, busy_o, done_o, err_o, err_code_o}, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_results", {sq_o, gt_o, lt_o}, 0);
        resetn = 1'b1;

        run(17'h10000, 16'h0180, 3, 3, -1, 1'b0, -1, 32'h0123_4567, 32'h000A_BCDE, 32'h0001_2345);
        run(17'h00A5A, 16'h1234, 99, 2, -1, 1'b0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(17'h1FFFF, 16'hFFFF, 2, 3, FIRST + 1, 1'b0, -1, 32'h1, 32'h2, 32'h3);
        run(17'h00001, 16'h0001, 1, 1, -1, 1'b0, -1, 32'hFE00_0001, 32'hFFE0_0002, 32'h0010_0003);
        run(17'h0BEEF, 16'h0F0F, 2, 2, -1, 1'b0, FIRST + 2, 32'h5, 32'h6, 32'h7);

        for (int r = 0; r < 8; r++) begin
            int ei;
            ei = (r % 3 == 2) ? $urandom_range(0, FIRST + 4) : -1;
            run(17'($urandom()), 16'($urandom()), $urandom_range(1, 5), $urandom_range(1, 4),
                ei, ($urandom_range(0, 1) == 1), -1, $urandom(), $urandom(), $urandom());
        end

        // Reset while a status poll is on the bus.
        t_lat = 3; t_dafter = 99; t_err = -1; t_hold = -1;
        poll_seen = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(poll_seen >= 2 && wb_cyc_o && !wb_we_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_poll", n < 2000, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_reset_cyc", {wb_cyc_o, wb_stb_o}, 0);
        chk("mid_reset_ctl", {wb_we_o, wb_adr_o, wb_sel_o, busy_o, done_o, err_o, err_code_o}, 0);
        chk("mid_reset_dat", wb_dat_o, 0);
        chk("mid_reset_results", {sq_o, gt_o, lt_o}, 0);
        resetn = 1'b1;
        m_sq = '0;
        m_gt = '0;
        m_lt = '0;

        run(17'h12345, 16'h8001, 4, 4, -1, 1'b0, -1, $urandom(), $urandom(), $urandom());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
